// File: rtl/cpu_pkg.sv
// Shared types for the 8-bit load/store core: opcode and system sub-op encodings,
// datapath and instruction widths, and the decoded instruction layout.
package cpu_pkg;
   localparam int DW = 8;
   localparam int IW = 9;

   typedef enum logic [2:0] {
      OP_MOV = 3'b000,
      OP_ADD = 3'b001,
      OP_XOR = 3'b010,
      OP_AND = 3'b011,
      OP_SHL = 3'b100,
      OP_SHR = 3'b101,
      OP_LDI = 3'b110,
      OP_SYS = 3'b111
   } opcode_t;

   typedef enum logic [2:0] {
      SYS_LD   = 3'b000,
      SYS_ST   = 3'b001,
      SYS_BNZ  = 3'b010,
      SYS_BZ   = 3'b011,
      SYS_DONE = 3'b111
   } sysop_t;

   typedef struct packed {
      opcode_t    op;
      logic [2:0] a;
      logic [2:0] b;
   } instr_t;
endpackage

// File: rtl/top_level_cpu_alu.sv
// Combinational ALU: result of op on (a, b); zero flags an all-zero result.
// Non-ALU opcodes pass b through, so zero then reports whether rB is zero.
module alu
   import cpu_pkg::*;
(
   input  opcode_t         op,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   output logic [DW-1:0]   y,
   output logic            zero
);
   always_comb begin
      y = b;
      case (op)
         OP_MOV:  y = b;
         OP_ADD:  y = a + b;
         OP_XOR:  y = a ^ b;
         OP_AND:  y = a & b;
         OP_SHL:  y = a << b[2:0];
         OP_SHR:  y = a >> b[2:0];
         default: y = b;
      endcase
   end

   assign zero = (y == '0);
endmodule

// File: rtl/top_level_cpu_mem.sv
// Instruction ROM (async read) and data RAM (async read, write on posedge).
// Contents are only ever loaded from outside the core and never cleared by reset.
module instr_rom
   import cpu_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic [PC_W-1:0] addr,
   output logic [IW-1:0]   dat
);
   logic [IW-1:0] core [2**PC_W];

   assign dat = core[addr];
endmodule

module data_mem
   import cpu_pkg::*;
#(
   parameter int DMEM_DEPTH = 256,
   parameter int AW         = $clog2(DMEM_DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdat,
   output logic [DW-1:0] rdat
);
   logic [DW-1:0] core [DMEM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) core[addr] <= wdat;
   end

   assign rdat = core[addr];
endmodule

// File: rtl/top_level_cpu.sv
// Single-cycle 8-bit load/store CPU: one instruction per clk, halts on DONE and holds done until req.
// Optional per-instruction trace when TOP_LEVEL_CPU_TRACE_EN is defined.
module top_level_cpu
   import cpu_pkg::*;
#(
   parameter int PC_W       = 8,
   parameter int DMEM_DEPTH = 256
) (
   input  logic clk,
   input  logic req,
   output logic done
);
   logic [PC_W-1:0] pc;
   logic            halted;
   logic [DW-1:0]   rf [8];

   logic [IW-1:0]   ins_raw;
   instr_t          ins;
   sysop_t          sub;
   logic [DW-1:0]   alu_y;
   logic            alu_zero;
   logic [DW-1:0]   mem_rdat;
   logic            mem_we;

   logic [PC_W-1:0] pc_next;
   logic            wr_en;
   logic [2:0]      wr_idx;
   logic [DW-1:0]   wr_val;
   logic            halt_now;

   instr_rom #(.PC_W(PC_W)) ir1 (
      .addr (pc),
      .dat  (ins_raw)
   );

   assign ins = instr_t'(ins_raw);
   assign sub = sysop_t'(ins.a);

   alu u_alu (
      .op   (ins.op),
      .a    (rf[ins.a]),
      .b    (rf[ins.b]),
      .y    (alu_y),
      .zero (alu_zero)
   );

   // r0 is the only data address register; with 256 bytes every address is in range
   assign mem_we = !req && !halted && (ins.op == OP_SYS) && (sub == SYS_ST);

   data_mem #(.DMEM_DEPTH(DMEM_DEPTH)) dm1 (
      .clk  (clk),
      .we   (mem_we),
      .addr (rf[0]),
      .wdat (rf[ins.b]),
      .rdat (mem_rdat)
   );

   always_comb begin
      pc_next  = pc + 1'b1;
      wr_en    = 1'b0;
      wr_idx   = ins.a;
      wr_val   = alu_y;
      halt_now = 1'b0;
      case (ins.op)
         OP_LDI: begin
            wr_en  = 1'b1;
            wr_idx = 3'd0;
            wr_val = {{(DW-6){1'b0}}, ins.a, ins.b};
         end
         OP_SYS: begin
            case (sub)
               SYS_LD: begin
                  wr_en  = 1'b1;
                  wr_idx = ins.b;
                  wr_val = mem_rdat;
               end
               SYS_BNZ:  if (!alu_zero) pc_next = PC_W'(rf[6]);
               SYS_BZ:   if (alu_zero)  pc_next = PC_W'(rf[6]);
               SYS_DONE: begin
                  halt_now = 1'b1;
                  pc_next  = pc;
               end
               default: ;
            endcase
         end
         default: wr_en = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (req) begin
         pc     <= '0;
         halted <= 1'b0;
         done   <= 1'b0;
         for (int i = 0; i < 8; i++) rf[i] <= '0;
      end else if (!halted) begin
         pc <= pc_next;
         if (wr_en) rf[wr_idx] <= wr_val;
         if (halt_now) begin
            halted <= 1'b1;
            done   <= 1'b1;
         end
      end
   end

`ifdef TOP_LEVEL_CPU_TRACE_EN
   logic [31:0] cyc;

   always_ff @(posedge clk) begin
      if (req) cyc <= '0;
      else     cyc <= cyc + 1'b1;
      if (!req && !halted) begin
         if (halt_now)
            $display("HALT @cycle %0d", cyc);
         else if (mem_we)
            $display("pc=%0d ins=%h mem[%0d]<=%h", pc, ins_raw, rf[0], rf[ins.b]);
         else if (wr_en)
            $display("pc=%0d ins=%h r%0d<=%h", pc, ins_raw, wr_idx, wr_val);
         else
            $display("pc=%0d ins=%h", pc, ins_raw);
      end
   end
`else
   // untraced build: no simulation output
`endif
endmodule

// File: tb/tb_top_level_cpu.sv
// Directed bench for top_level_cpu: reset, copy, restart, DONE under reset, ALU ops,
// branch loop and a 30-byte block copy checked against a bench-side model.
module tb_top_level_cpu;
   logic clk = 1'b0;
   logic req = 1'b1;
   logic done;

   int n_total = 0;
   int n_bad   = 0;

   localparam logic [2:0] MOV = 3'b000, ADD = 3'b001, XOR = 3'b010, AND = 3'b011;
   localparam logic [2:0] SHL = 3'b100, SHR = 3'b101;
   localparam logic [2:0] LD = 3'b000, ST = 3'b001, BNZ = 3'b010, BZ = 3'b011, DN = 3'b111;

   top_level_cpu dut (
      .clk  (clk),
      .req  (req),
      .done (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] rr(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
      return {op, a, b};
   endfunction

   function automatic logic [8:0] ldi(input logic [5:0] imm);
      return {3'b110, imm};
   endfunction

   function automatic logic [8:0] sys(input logic [2:0] s, input logic [2:0] b);
      return {3'b111, s, b};
   endfunction

   logic [8:0] prog [$];

   task automatic load_prog();
      for (int i = 0; i < 256; i++) dut.ir1.core[i] <= sys(DN, 3'd0);
      for (int i = 0; i < prog.size(); i++) dut.ir1.core[i] <= prog[i];
      #1;
   endtask

   task automatic run_prog(input int max_cyc, output int cyc);
      req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < max_cyc) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("run_done", {31'd0, done}, 32'd1);
   endtask

   logic [7:0] model [30];
   int cyc;

   initial begin
      // reset state with a simple copy program preloaded
      prog = {ldi(6'd0), sys(LD, 3'd1), ldi(6'd30), sys(ST, 3'd1), sys(DN, 3'd0)};
      load_prog();
      dut.dm1.core[0]   <= 8'h55;
      dut.dm1.core[30]  <= 8'h00;
      dut.dm1.core[100] <= 8'hA5;
      req = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc", {24'd0, dut.pc}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      for (int i = 0; i < 8; i++) check($sformatf("rst_r%0d", i), {24'd0, dut.rf[i]}, 32'd0);
      check("rst_mem_kept", {24'd0, dut.dm1.core[100]}, 32'h0A5);

      // copy: done rises exactly on the 5th edge after req drops
      req = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("copy_done_early", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
      check("copy_done", {31'd0, done}, 32'd1);
      check("copy_mem30", {24'd0, dut.dm1.core[30]}, 32'h55);
      repeat (3) @(posedge clk);
      #1;
      check("copy_done_held", {31'd0, done}, 32'd1);

      // restart after done
      dut.dm1.core[30] <= 8'h00;
      req = 1'b1;
      @(posedge clk); #1;
      check("restart_done_clr", {31'd0, done}, 32'd0);
      req = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("restart_done", {31'd0, done}, 32'd1);
      check("restart_cycles", cyc, 5);
      check("restart_mem30", {24'd0, dut.dm1.core[30]}, 32'h55);

      // DONE at pc 0 must be ignored while req is held
      prog = {};
      load_prog();
      req = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("done_under_req", {31'd0, done}, 32'd0);
      req = 1'b0;
      @(posedge clk); #1;
      check("done_after_req", {31'd0, done}, 32'd1);

      // ALU operations, results stored to mem[40..44]
      prog = {ldi(6'd50), rr(MOV, 3'd1, 3'd0), rr(MOV, 3'd2, 3'd0), ldi(6'd2), rr(SHL, 3'd1, 3'd0),
              ldi(6'd1), rr(SHL, 3'd2, 3'd0), rr(ADD, 3'd1, 3'd2), ldi(6'd40), sys(ST, 3'd1),
              ldi(6'd60), rr(MOV, 3'd3, 3'd0), rr(MOV, 3'd4, 3'd0), ldi(6'd2), rr(SHL, 3'd3, 3'd0),
              rr(XOR, 3'd3, 3'd4), ldi(6'd41), sys(ST, 3'd3),
              ldi(6'd32), rr(MOV, 3'd5, 3'd0), ldi(6'd2), rr(SHL, 3'd5, 3'd0), ldi(6'd1),
              rr(MOV, 3'd7, 3'd0), rr(XOR, 3'd5, 3'd7), rr(MOV, 3'd2, 3'd3), rr(AND, 3'd2, 3'd5),
              ldi(6'd44), sys(ST, 3'd2), rr(MOV, 3'd3, 3'd5), rr(SHL, 3'd5, 3'd7), ldi(6'd42),
              sys(ST, 3'd5), ldi(6'd7), rr(SHR, 3'd3, 3'd0), ldi(6'd43), sys(ST, 3'd3), sys(DN, 3'd0)};
      load_prog();
      for (int i = 40; i < 45; i++) dut.dm1.core[i] <= 8'hEE;
      run_prog(100, cyc);
      check("alu_add_wrap", {24'd0, dut.dm1.core[40]}, 32'd44);
      check("alu_xor", {24'd0, dut.dm1.core[41]}, 32'hCC);
      check("alu_shl", {24'd0, dut.dm1.core[42]}, 32'h02);
      check("alu_shr", {24'd0, dut.dm1.core[43]}, 32'h01);
      check("alu_and", {24'd0, dut.dm1.core[44]}, 32'h80);

      // BNZ loop runs 3 times, BZ skips a DONE, iteration count stored to mem[50]
      prog = {ldi(6'd3), rr(MOV, 3'd1, 3'd0), ldi(6'd1), rr(MOV, 3'd3, 3'd0),
              ldi(6'd63), rr(MOV, 3'd7, 3'd0), ldi(6'd2), rr(SHL, 3'd7, 3'd0), ldi(6'd3),
              rr(XOR, 3'd7, 3'd0), ldi(6'd12), rr(MOV, 3'd6, 3'd0),
              rr(ADD, 3'd1, 3'd7), rr(ADD, 3'd2, 3'd3), sys(BNZ, 3'd1),
              ldi(6'd19), rr(MOV, 3'd6, 3'd0), sys(BZ, 3'd1), sys(DN, 3'd0),
              ldi(6'd50), sys(ST, 3'd2), sys(DN, 3'd0)};
      load_prog();
      dut.dm1.core[50] <= 8'hEE;
      run_prog(100, cyc);
      check("loop_count", {24'd0, dut.dm1.core[50]}, 32'd3);
      check("loop_cycles", cyc, 27);

      // block copy mem[0:29] -> mem[30:59]
      prog = {ldi(6'd2), rr(MOV, 3'd1, 3'd0), ldi(6'd63), rr(MOV, 3'd5, 3'd0), rr(SHL, 3'd5, 3'd1),
              ldi(6'd3), rr(XOR, 3'd5, 3'd0), ldi(6'd1), rr(MOV, 3'd7, 3'd0), ldi(6'd30),
              rr(MOV, 3'd3, 3'd0), rr(MOV, 3'd4, 3'd0), ldi(6'd0), rr(MOV, 3'd2, 3'd0),
              ldi(6'd16), rr(MOV, 3'd6, 3'd0),
              rr(MOV, 3'd0, 3'd2), sys(LD, 3'd1), rr(ADD, 3'd0, 3'd3), sys(ST, 3'd1),
              rr(ADD, 3'd2, 3'd7), rr(ADD, 3'd4, 3'd5), sys(BNZ, 3'd4), sys(DN, 3'd0)};
      load_prog();
      model[0] = 8'h55;
      model[1] = 8'h05;
      for (int i = 2; i < 30; i++) model[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 30; i++) begin
         dut.dm1.core[i]      <= model[i];
         dut.dm1.core[30 + i] <= 8'h00;
      end
      run_prog(1000, cyc);
      check("p1_cycles", cyc, 227);
      for (int i = 0; i < 30; i++)
         check($sformatf("p1_mem%0d", 30 + i), {24'd0, dut.dm1.core[30 + i]}, {24'd0, model[i]});
      check("p1_src0_kept", {24'd0, dut.dm1.core[0]}, 32'h55);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
